// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: state encodings, ctrl bit indices and pc_sel codes for cpu_sequencer.
package cpu_seq_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_e;
    localparam int CTRL_AUIPC     = 6;
    localparam int CTRL_BRANCH    = 5;
    localparam int CTRL_JUMP      = 4;
    localparam int CTRL_IMMEDIATE = 3;
    localparam int CTRL_MEMREAD   = 2;
    localparam int CTRL_MEMWRITE  = 1;
    localparam int CTRL_REGWRITE  = 0;
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
endpackage

// File: rtl/seq_wdt.sv
// seq_wdt: memory-wait watchdog; expired fires on the LIMIT-th pending cycle since the last clear.
module seq_wdt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam logic [15:0] LAST = 16'(LIMIT - 1);
    logic [15:0] cnt_q, cnt_d;
    assign cnt_d   = clear ? 16'd0 : cnt_q + 16'(tick);
    assign expired = tick && (cnt_q == LAST);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= 16'd0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM.
// Define SEQ_TIMEOUT_EN to enable the memory-wait watchdog and the sticky ERR state.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [6:0]  ctrl,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_src_imm,
    output logic        alu_a_pc,
    output logic        rf_we,
    output logic        wb_sel_mem,
    output logic        retire,
    output logic        illegal_instr,
    output logic        bus_err,
    output logic [31:0] instr_cnt,
    output logic [2:0]  state
);
    state_e      state_q, state_d;
    logic [6:0]  ctrl_q, ctrl_d;
    logic [31:0] cnt_q, cnt_d;
    logic        timeout;
    logic        is_mem;
`ifdef SEQ_TIMEOUT_EN
    seq_wdt #(.LIMIT(TIMEOUT_CYCLES)) u_wdt (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_d != state_q),
        .tick    ((imem_req & ~imem_ack) | (dmem_req & ~dmem_ack)),
        .expired (timeout)
    );
    assign bus_err = (state_q == S_ERR);
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif
    assign is_mem    = ctrl_q[CTRL_MEMREAD] | ctrl_q[CTRL_MEMWRITE];
    assign ctrl_d    = (state_q == S_DECODE) ? ctrl : ctrl_q;
    assign cnt_d     = cnt_q + 32'(retire);
    assign retire    = pc_we;
    assign instr_cnt = cnt_q;
    assign state     = state_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= 7'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = !run ? S_FETCH : imem_ack ? S_DECODE : timeout ? S_ERR : S_FETCH;
            S_DECODE: state_d = (ctrl == 7'd0) ? S_FETCH : S_EXEC;
            S_EXEC:   state_d = (ctrl_q[CTRL_BRANCH] | ctrl_q[CTRL_JUMP]) ? S_FETCH :
                                is_mem ? S_MEM : ctrl_q[CTRL_REGWRITE] ? S_WB : S_FETCH;
            S_MEM:    state_d = dmem_ack ? (ctrl_q[CTRL_MEMREAD] ? S_WB : S_FETCH) :
                                timeout ? S_ERR : S_MEM;
            S_WB:     state_d = S_FETCH;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_FETCH;
        endcase
    end
    // Gating on reset drops requests asynchronously, not just at the next edge.
    always_comb begin
        imem_req      = 1'b0;
        ir_we         = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        mdr_we        = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = PC_PLUS4;
        alu_src_imm   = 1'b0;
        alu_a_pc      = 1'b0;
        rf_we         = 1'b0;
        wb_sel_mem    = 1'b0;
        illegal_instr = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = run;
                    ir_we    = run & imem_ack;
                end
                S_DECODE: begin
                    illegal_instr = (ctrl == 7'd0);
                    pc_we         = (ctrl == 7'd0);
                end
                S_EXEC: begin
                    alu_src_imm = ctrl_q[CTRL_IMMEDIATE];
                    alu_a_pc    = ctrl_q[CTRL_AUIPC];
                    pc_we       = ctrl_q[CTRL_BRANCH] | ctrl_q[CTRL_JUMP] |
                                  ~(is_mem | ctrl_q[CTRL_REGWRITE]);
                    pc_sel      = ctrl_q[CTRL_BRANCH] ? (branch_taken ? PC_BRANCH : PC_PLUS4) :
                                  ctrl_q[CTRL_JUMP] ? PC_JUMP : PC_PLUS4;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = ctrl_q[CTRL_MEMWRITE];
                    mdr_we   = dmem_ack & ctrl_q[CTRL_MEMREAD];
                    pc_we    = dmem_ack & ~ctrl_q[CTRL_MEMREAD];
                end
                S_WB: begin
                    rf_we      = 1'b1;
                    wb_sel_mem = ctrl_q[CTRL_MEMREAD];
                    pc_we      = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the memory-wait limit in cycles; range 1..65535.
REQ-002 SHALL have port clk  input  1  system clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port run  input  1  permits a new fetch when high.
REQ-005 SHALL have port ctrl  input  7  decoder control: [6]auipc [5]branch [4]jump [3]immediate [2]memRead [1]memWrite [0]regWrite.
REQ-006 SHALL have port branch_taken  input  1  ALU compare result, valid in EXEC.
REQ-007 SHALL have ports imem_req output 1, imem_ack input 1, dmem_req output 1, dmem_we output 1, dmem_ack input 1 for the memory handshakes.
REQ-008 SHALL have port ir_we  output  1  instruction register load.
REQ-009 SHALL have port mdr_we  output  1  load-data register load.
REQ-010 SHALL have ports pc_we output 1 and pc_sel output 2 (0 = PC+4, 1 = branch target, 2 = jump target).
REQ-011 SHALL have ports alu_src_imm output 1, alu_a_pc output 1, rf_we output 1, wb_sel_mem output 1.
REQ-012 SHALL have ports retire output 1, illegal_instr output 1, bus_err output 1, instr_cnt output 32, state output 3.

Function
REQ-013 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5; all other codes SHALL return to FETCH.
REQ-014 FETCH: imem_req SHALL be high while run=1; it SHALL be held until imem_ack; in the ack cycle ir_we=1 and the next state SHALL be DECODE. With run=0 the block SHALL idle in FETCH with no request.
REQ-015 DECODE: the block SHALL register ctrl into ctrl_q; ctrl=0 SHALL pulse illegal_instr and pc_we (pc_sel=0) for one cycle and return to FETCH; otherwise next state SHALL be EXEC.
REQ-016 EXEC (one cycle): alu_src_imm=ctrl_q[3] and alu_a_pc=ctrl_q[6].
REQ-017 EXEC priority: branch sets pc_we=1, pc_sel=branch_taken?1:0, then FETCH; else jump sets pc_we=1, pc_sel=2, then FETCH; else memRead|memWrite goes to MEM; else regWrite goes to WB; else pc_we=1, pc_sel=0, then FETCH.
REQ-018 MEM: dmem_req SHALL be high and dmem_we=ctrl_q[1], both held stable until dmem_ack. On ack: memRead sets mdr_we=1 and goes to WB; otherwise pc_we=1, pc_sel=0, then FETCH.
REQ-019 WB (one cycle): rf_we=1, wb_sel_mem=ctrl_q[2], pc_we=1, pc_sel=0, then FETCH.
REQ-020 retire SHALL equal pc_we, and instr_cnt SHALL increment on every retire, wrapping from 0xFFFFFFFF to 0.
REQ-021 An ack arriving while the corresponding req is low SHALL be ignored.
REQ-022 Deasserting run mid-instruction SHALL NOT abort it; run is sampled only in FETCH.
REQ-023 Strobes (ir_we, mdr_we, pc_we, rf_we, illegal_instr, retire) SHALL be single-cycle pulses; at most one pc_we SHALL occur per instruction.

Reset
REQ-024 On reset: state=FETCH, ctrl_q=0, instr_cnt=0, bus_err=0, and all other outputs SHALL be 0.
REQ-025 Reset during MEM or FETCH SHALL drop the request immediately (asynchronously).

Configuration
REQ-026 The macro SEQ_TIMEOUT_EN SHALL control the memory-wait watchdog.
REQ-027 When SEQ_TIMEOUT_EN is defined: a wait counter SHALL clear on entry to FETCH or MEM and increment each cycle a request is pending without ack; on reaching TIMEOUT_CYCLES the block SHALL enter ERR with bus_err=1. The ERR state SHALL be sticky until reset, with no requests and no strobes.
REQ-028 When SEQ_TIMEOUT_EN is undefined: the block SHALL wait indefinitely, bus_err SHALL be tied to 0, and ERR SHALL be unreachable.

Structure
REQ-029 The package cpu_seq_pkg SHALL hold the state encodings, the ctrl bit index constants (CTRL_AUIPC..CTRL_REGWRITE), and the pc_sel encodings.
REQ-030 The watchdog SHALL be the sub-module seq_wdt (ports clk, reset, clear, tick, expired), instantiated only under SEQ_TIMEOUT_EN.

Verification
REQ-031 R-type: ctrl=0x01, imem_ack in cycle 2 -> the state sequence SHALL be FETCH, FETCH, DECODE, EXEC, WB, with rf_we and pc_we in WB and instr_cnt=1.
REQ-032 Load: ctrl=0x0D, dmem_ack after 3 wait cycles -> dmem_req SHALL be high for 4 cycles with dmem_we=0, then mdr_we, then rf_we with wb_sel_mem=1.
REQ-033 Branch: ctrl=0x28, branch_taken=1 -> pc_sel=1; with branch_taken=0 -> pc_sel=0; rf_we SHALL never assert.
REQ-034 Illegal: ctrl=0x00 -> illegal_instr and pc_we pulse in DECODE, followed by a return to FETCH, and instr_cnt increments.
REQ-035 Timeout (SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4): store with no dmem_ack -> ERR after 4 wait cycles with bus_err=1; dmem_req SHALL drop and the block SHALL stay in ERR until reset.
REQ-036 Wrap: instr_cnt forced to 0xFFFFFFFF, then one retire -> instr_cnt=0.
